// File: rtl/rot_sat_accum_bank.sv
// Bank of NCH unsigned accumulators stepped by rotary-shaft events, with
// per-channel saturate-or-wrap arithmetic, clear, sticky overflow and update strobe.
module rot_sat_accum_bank #(
    parameter int WIDTH  = 4,
    parameter int NCH    = 2,
    parameter int CH_W   = 1,
    parameter int STEP_W = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rot_event,
    input  logic                   sub,
    input  logic [CH_W-1:0]        ch_sel,
    input  logic [STEP_W-1:0]      step,
    input  logic                   wrap_mode,
    input  logic                   clr,
    output logic [NCH*WIDTH-1:0]   acc_flat,
    output logic [NCH-1:0]         ovf_flag,
    output logic                   upd_valid,
    output logic [CH_W-1:0]        upd_ch
);

    logic [NCH*WIDTH-1:0] acc_q, acc_d;
    logic [NCH-1:0]       ovf_q, ovf_d;
    logic                 upd_valid_q, upd_valid_d;
    logic [CH_W-1:0]      upd_ch_q, upd_ch_d;
    logic                 rot_q;

    logic                 evt_s;
    logic                 ch_in_range_s;
    logic [WIDTH-1:0]     sel_acc_s;
    logic [WIDTH:0]       step_ext_s;
    logic [WIDTH:0]       sum_s;
    logic [WIDTH:0]       dif_s;
    logic [WIDTH-1:0]     new_val_s;
    logic                 ovf_ev_s;

    assign evt_s         = rot_event & ~rot_q;
    assign ch_in_range_s = (int'(ch_sel) < NCH);
    assign step_ext_s    = {{(WIDTH + 1 - STEP_W){1'b0}}, step};

    // Mux out the currently addressed channel.
    always_comb begin
        sel_acc_s = {WIDTH{1'b0}};
        for (int k = 0; k < NCH; k++) begin
            sel_acc_s = (int'(ch_sel) == k) ? acc_q[k*WIDTH +: WIDTH] : sel_acc_s;
        end
    end

    // Step arithmetic; the extra top bit of sum/difference is the carry/borrow.
    always_comb begin
        sum_s     = {1'b0, sel_acc_s} + step_ext_s;
        dif_s     = {1'b0, sel_acc_s} - step_ext_s;
        ovf_ev_s  = 1'b0;
        new_val_s = {WIDTH{1'b0}};
        if (sub) begin
            ovf_ev_s  = dif_s[WIDTH];
            new_val_s = (dif_s[WIDTH] && !wrap_mode) ? {WIDTH{1'b0}} : dif_s[WIDTH-1:0];
        end else begin
            ovf_ev_s  = sum_s[WIDTH];
            new_val_s = (sum_s[WIDTH] && !wrap_mode) ? {WIDTH{1'b1}} : sum_s[WIDTH-1:0];
        end
    end

    // Next state: clear beats a coincident event, which is then lost for good.
    always_comb begin
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        upd_valid_d = 1'b0;
        upd_ch_d    = upd_ch_q;
        for (int k = 0; k < NCH; k++) begin
            if (ch_in_range_s && (int'(ch_sel) == k)) begin
                if (clr) begin
                    acc_d[k*WIDTH +: WIDTH] = {WIDTH{1'b0}};
                    ovf_d[k]                = 1'b0;
                end else if (evt_s) begin
                    acc_d[k*WIDTH +: WIDTH] = new_val_s;
                    ovf_d[k]                = ovf_q[k] | ovf_ev_s;
                end else begin
                    acc_d[k*WIDTH +: WIDTH] = acc_q[k*WIDTH +: WIDTH];
                end
            end else begin
                ovf_d[k] = ovf_q[k];
            end
        end
        if (ch_in_range_s && clr) begin
            upd_ch_d = ch_sel;
        end else if (ch_in_range_s && evt_s) begin
            upd_valid_d = 1'b1;
            upd_ch_d    = ch_sel;
        end else begin
            upd_ch_d = upd_ch_q;
        end
    end

    // State registers; rot_q resets high so a level held through reset is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= {(NCH*WIDTH){1'b0}};
            ovf_q       <= {NCH{1'b0}};
            upd_valid_q <= 1'b0;
            upd_ch_q    <= {CH_W{1'b0}};
            rot_q       <= 1'b1;
        end else begin
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            upd_valid_q <= upd_valid_d;
            upd_ch_q    <= upd_ch_d;
            rot_q       <= rot_event;
        end
    end

    assign acc_flat  = acc_q;
    assign ovf_flag  = ovf_q;
    assign upd_valid = upd_valid_q;
    assign upd_ch    = upd_ch_q;

endmodule

// File: tb/tb_rot_sat_accum_bank.sv
// Scoreboard bench for rot_sat_accum_bank: three builds, directed events,
// monitors pop expected results whenever upd_valid is seen.
module tb_rot_sat_accum_bank;

    typedef struct {
        int          ch;
        logic [31:0] acc;
        logic [3:0]  ovf;
    } exp_t;

    logic clk;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    // Build A: WIDTH=4 NCH=2 CH_W=1 STEP_W=2
    logic       rst_a, a_rot, a_sub, a_sel, a_wrap, a_clr, a_uv, a_uch;
    logic [1:0] a_step, a_ovf;
    logic [7:0] a_acc;
    // Build B: WIDTH=4 NCH=3 CH_W=2 STEP_W=2
    logic        rst_b, b_rot, b_sub, b_wrap, b_clr, b_uv;
    logic [1:0]  b_sel, b_step, b_uch;
    logic [2:0]  b_ovf;
    logic [11:0] b_acc;
    // Build C: WIDTH=8 NCH=4 CH_W=2 STEP_W=4
    logic        rst_c, c_rot, c_sub, c_wrap, c_clr, c_uv;
    logic [1:0]  c_sel, c_uch;
    logic [3:0]  c_step, c_ovf;
    logic [31:0] c_acc;

    rot_sat_accum_bank #(.WIDTH(4), .NCH(2), .CH_W(1), .STEP_W(2)) dut_a (
        .clk(clk), .rst_n(rst_a), .rot_event(a_rot), .sub(a_sub), .ch_sel(a_sel),
        .step(a_step), .wrap_mode(a_wrap), .clr(a_clr), .acc_flat(a_acc),
        .ovf_flag(a_ovf), .upd_valid(a_uv), .upd_ch(a_uch));

    rot_sat_accum_bank #(.WIDTH(4), .NCH(3), .CH_W(2), .STEP_W(2)) dut_b (
        .clk(clk), .rst_n(rst_b), .rot_event(b_rot), .sub(b_sub), .ch_sel(b_sel),
        .step(b_step), .wrap_mode(b_wrap), .clr(b_clr), .acc_flat(b_acc),
        .ovf_flag(b_ovf), .upd_valid(b_uv), .upd_ch(b_uch));

    rot_sat_accum_bank #(.WIDTH(8), .NCH(4), .CH_W(2), .STEP_W(4)) dut_c (
        .clk(clk), .rst_n(rst_c), .rot_event(c_rot), .sub(c_sub), .ch_sel(c_sel),
        .step(c_step), .wrap_mode(c_wrap), .clr(c_clr), .acc_flat(c_acc),
        .ovf_flag(c_ovf), .upd_valid(c_uv), .upd_ch(c_uch));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitors: every upd_valid pulse must match the oldest expected entry.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (a_uv === 1'b1) begin
            if (qa.size() == 0) chk("a_unexpected_upd", 32'(a_uv), 32'd0);
            else begin
                e = qa.pop_front();
                chk("a_acc", 32'(a_acc), e.acc);
                chk("a_ovf", 32'(a_ovf), 32'(e.ovf));
                chk("a_upd_ch", 32'(a_uch), 32'(e.ch));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (b_uv === 1'b1) begin
            if (qb.size() == 0) chk("b_unexpected_upd", 32'(b_uv), 32'd0);
            else begin
                e = qb.pop_front();
                chk("b_acc", 32'(b_acc), e.acc);
                chk("b_ovf", 32'(b_ovf), 32'(e.ovf));
                chk("b_upd_ch", 32'(b_uch), 32'(e.ch));
            end
        end
    end

    always @(negedge clk) begin : mon_c
        exp_t e;
        if (c_uv === 1'b1) begin
            if (qc.size() == 0) chk("c_unexpected_upd", 32'(c_uv), 32'd0);
            else begin
                e = qc.pop_front();
                chk("c_acc", 32'(c_acc), e.acc);
                chk("c_ovf", 32'(c_ovf), 32'(e.ovf));
                chk("c_upd_ch", 32'(c_uch), 32'(e.ch));
            end
        end
    end

    task automatic a_ev(input logic ch, input logic sb, input logic [1:0] st, input logic wr,
                        input logic [7:0] eacc, input logic [1:0] eovf);
        exp_t e;
        a_sel = ch; a_sub = sb; a_step = st; a_wrap = wr; a_rot = 1'b1;
        e.ch = int'(ch); e.acc = 32'(eacc); e.ovf = 4'(eovf);
        qa.push_back(e);
        tick(1);
        a_rot = 1'b0;
        tick(1);
    endtask

    task automatic b_ev(input logic [1:0] ch, input logic [1:0] st, input logic [11:0] eacc,
                        input logic push);
        exp_t e;
        b_sel = ch; b_sub = 1'b0; b_step = st; b_wrap = 1'b0; b_rot = 1'b1;
        e.ch = int'(ch); e.acc = 32'(eacc); e.ovf = 4'd0;
        if (push) qb.push_back(e);
        tick(1);
        b_rot = 1'b0;
        tick(1);
    endtask

    task automatic c_ev(input logic [1:0] ch, input logic [3:0] st, input logic [31:0] eacc,
                        input logic [3:0] eovf);
        exp_t e;
        c_sel = ch; c_sub = 1'b0; c_step = st; c_wrap = 1'b0; c_rot = 1'b1;
        e.ch = int'(ch); e.acc = eacc; e.ovf = eovf;
        qc.push_back(e);
        tick(1);
        c_rot = 1'b0;
        tick(1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        a_rot = 1'b1; a_sub = 1'b0; a_sel = 1'b0; a_step = 2'd0; a_wrap = 1'b0; a_clr = 1'b0;
        b_rot = 1'b0; b_sub = 1'b0; b_sel = 2'd0; b_step = 2'd0; b_wrap = 1'b0; b_clr = 1'b0;
        c_rot = 1'b0; c_sub = 1'b0; c_sel = 2'd0; c_step = 4'd0; c_wrap = 1'b0; c_clr = 1'b0;
        tick(2);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        tick(3);
        chk("a_reset_acc", 32'(a_acc), 32'd0);
        chk("a_reset_ovf", 32'(a_ovf), 32'd0);
        chk("a_reset_uv", 32'(a_uv), 32'd0);
        chk("a_reset_uch", 32'(a_uch), 32'd0);
        a_rot = 1'b0;
        tick(1);

        // Build A: bring-up, saturate/wrap add on ch1, saturate/wrap sub on ch0
        a_ev(1'b0, 1'b0, 2'd3, 1'b0, 8'h03, 2'b00);
        a_ev(1'b1, 1'b0, 2'd3, 1'b0, 8'h33, 2'b00);
        a_ev(1'b1, 1'b0, 2'd3, 1'b0, 8'h63, 2'b00);
        a_ev(1'b1, 1'b0, 2'd3, 1'b0, 8'h93, 2'b00);
        a_ev(1'b1, 1'b0, 2'd3, 1'b0, 8'hC3, 2'b00);
        a_ev(1'b1, 1'b0, 2'd2, 1'b0, 8'hE3, 2'b00);
        a_ev(1'b1, 1'b0, 2'd3, 1'b0, 8'hF3, 2'b10);
        a_ev(1'b1, 1'b1, 2'd1, 1'b0, 8'hE3, 2'b10);
        a_ev(1'b1, 1'b0, 2'd3, 1'b1, 8'h13, 2'b10);
        a_ev(1'b0, 1'b1, 2'd1, 1'b0, 8'h12, 2'b10);
        a_ev(1'b0, 1'b1, 2'd3, 1'b0, 8'h10, 2'b11);
        a_ev(1'b0, 1'b0, 2'd2, 1'b0, 8'h12, 2'b11);
        a_ev(1'b0, 1'b1, 2'd3, 1'b1, 8'h1F, 2'b11);
        a_ev(1'b0, 1'b0, 2'd0, 1'b0, 8'h1F, 2'b11);

        // Level held high for 5 cycles gives a single update
        begin
            exp_t e;
            a_sel = 1'b0; a_sub = 1'b1; a_step = 2'd1; a_wrap = 1'b0; a_rot = 1'b1;
            e.ch = 0; e.acc = 32'h1E; e.ovf = 4'b0011;
            qa.push_back(e);
            tick(5);
            a_rot = 1'b0;
            tick(1);
        end
        chk("a_held_acc", 32'(a_acc), 32'h1E);

        // Clear and event together on ch1 = 9: clear wins, event is lost
        a_ev(1'b1, 1'b0, 2'd3, 1'b0, 8'h4E, 2'b11);
        a_ev(1'b1, 1'b0, 2'd3, 1'b0, 8'h7E, 2'b11);
        a_ev(1'b1, 1'b0, 2'd2, 1'b0, 8'h9E, 2'b11);
        a_sel = 1'b1; a_sub = 1'b0; a_step = 2'd1; a_clr = 1'b1; a_rot = 1'b1;
        tick(1);
        a_clr = 1'b0;
        chk("a_clr_acc", 32'(a_acc), 32'h0E);
        chk("a_clr_ovf", 32'(a_ovf), 32'b01);
        chk("a_clr_uv", 32'(a_uv), 32'd0);
        tick(2);
        chk("a_clr_noretake", 32'(a_acc), 32'h0E);
        a_rot = 1'b0;
        tick(1);
        a_ev(1'b1, 1'b0, 2'd1, 1'b0, 8'h1E, 2'b01);
        a_sel = 1'b0; a_clr = 1'b1;
        tick(1);
        a_clr = 1'b0;
        chk("a_clr0_acc", 32'(a_acc), 32'h10);
        chk("a_clr0_ovf", 32'(a_ovf), 32'b00);
        chk("a_clr0_uch", 32'(a_uch), 32'd0);

        // Build B: out-of-range channel 3 is dropped for events and clears
        b_rot = 1'b0;
        tick(1);
        b_ev(2'd3, 2'd1, 12'h000, 1'b0);
        chk("b_drop_acc", 32'(b_acc), 32'd0);
        b_ev(2'd2, 2'd1, 12'h100, 1'b1);
        b_sel = 2'd3; b_clr = 1'b1;
        tick(1);
        b_clr = 1'b0;
        chk("b_clr_oor_acc", 32'(b_acc), 32'h100);
        chk("b_clr_oor_uch", 32'(b_uch), 32'd2);

        // Build C: add 15 seventeen times on ch2, then one more saturates
        for (int k = 1; k <= 17; k++) begin
            c_ev(2'd2, 4'd15, 32'(15 * k) << 16, 4'b0000);
        end
        c_ev(2'd2, 4'd15, 32'h00FF_0000, 4'b0100);
        chk("c_sat_acc", c_acc, 32'h00FF_0000);

        // Reset mid-operation clears outputs without a clock edge
        c_sel = 2'd0; c_step = 4'd1; c_rot = 1'b1;
        #2;
        rst_c = 1'b0;
        #1;
        chk("c_async_acc", c_acc, 32'd0);
        chk("c_async_ovf", 32'(c_ovf), 32'd0);
        chk("c_async_uv", 32'(c_uv), 32'd0);
        chk("c_async_uch", 32'(c_uch), 32'd0);
        tick(2);
        rst_c = 1'b1;
        tick(3);
        chk("c_post_rst_acc", c_acc, 32'd0);
        c_rot = 1'b0;
        tick(1);
        c_ev(2'd1, 4'd5, 32'h0000_0500, 4'b0000);

        tick(3);
        chk("qa_drained", 32'(qa.size()), 32'd0);
        chk("qb_drained", 32'(qb.size()), 32'd0);
        chk("qc_drained", 32'(qc.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rot_sat_accum_bank.md
Name: rot_sat_accum_bank

Overview:
- Parametrised bank of NCH unsigned accumulators, each WIDTH bits, stepped by rotary-shaft events.
- Each event adds or subtracts a STEP_W-bit step to one selected channel, with per-channel saturate-or-wrap arithmetic.
- Sits between the rotary-shaft decoder (which produces the event level) and the display/LED logic (which reads the accumulators).
- Adds per-channel clear, sticky overflow flags and an update strobe.

Parameters:
- WIDTH, 4: accumulator width in bits per channel (>= 2).
- NCH, 2: number of channels (>= 1).
- CH_W, 1: width of ch_sel; NCH <= 2**CH_W.
- STEP_W, 2: width of step (1 <= STEP_W <= WIDTH).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rot_event  in  1  level from the rotary-shaft decoder; a 0->1 transition sampled on clk is one event.
- sub  in  1  1 = subtract step, 0 = add step; sampled on the event cycle.
- ch_sel  in  CH_W  target channel index; sampled on the event cycle.
- step  in  STEP_W  unsigned step magnitude; sampled on the event cycle.
- wrap_mode  in  1  1 = modulo-2^WIDTH arithmetic, 0 = saturating arithmetic.
- clr  in  1  synchronous clear of channel ch_sel.
- acc_flat  out  NCH*WIDTH  registered accumulators; channel k occupies bits [k*WIDTH +: WIDTH].
- ovf_flag  out  NCH  sticky per-channel overflow/underflow flag.
- upd_valid  out  1  one-cycle pulse, high in the cycle after an accepted update.
- upd_ch  out  CH_W  channel index of the last accepted update or clear.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - all accumulators = 0, ovf_flag = 0, upd_valid = 0, upd_ch = 0;
  - the internal previous-event register rot_q = 1, so a rot_event held high through reset release is not counted.
- Edge detect: evt = rot_event & ~rot_q. rot_q <= rot_event every cycle; no other synchronisation is done (the decoder output is already synchronous).
- Accept condition: evt = 1 and ch_sel < NCH. If ch_sel >= NCH, the event is dropped: no state change, upd_valid stays 0.
- Arithmetic (accepted event, channel c, a = acc[c], s = step zero-extended to WIDTH+1 bits):
  - add: t = a + s on WIDTH+1 bits. If t[WIDTH] = 1, then acc[c] <= all-ones when wrap_mode = 0, or t[WIDTH-1:0] when wrap_mode = 1; ovf_flag[c] <= 1. Otherwise acc[c] <= t[WIDTH-1:0].
  - sub: t = a - s on WIDTH+1 bits. If s > a, then acc[c] <= 0 when wrap_mode = 0, or t[WIDTH-1:0] when wrap_mode = 1; ovf_flag[c] <= 1. Otherwise acc[c] <= t[WIDTH-1:0].
  - step = 0 is a valid event: the value is unchanged and upd_valid still pulses.
- Latency: the accumulator updates at the same clk edge that sees the event; acc_flat shows the new value from the next cycle, coincident with upd_valid = 1 and upd_ch = c.
- Clear:
  - clr = 1 with ch_sel < NCH sets acc[ch_sel] <= 0 and ovf_flag[ch_sel] <= 0, and sets upd_ch = ch_sel.
  - Clear does not pulse upd_valid.
  - clr with ch_sel out of range is ignored.
- Simultaneous clr and evt: clr wins and the event is discarded (not deferred). rot_q still updates, so the event is not retaken later.
- Other channels are never modified by an event or clear on channel c.
- One event per 0->1 transition: rot_event held high for N cycles yields exactly one update.
- Reset asserted mid-operation clears everything immediately, regardless of clk.

Test Plan:
- Reset with rot_event = 1 held, then release -> no update, acc_flat = 0, upd_valid stays 0. Drop rot_event, then raise it with ch 0, add, step 3 -> acc0 = 3, upd_valid pulses once with upd_ch = 0.
- Saturate add: acc1 = 14, add step 3, wrap_mode = 0 -> acc1 = 15 and ovf_flag[1] = 1. Same again with wrap_mode = 1 from 14 -> acc1 = 1.
- Saturate sub: acc0 = 2, sub step 3, wrap_mode = 0 -> acc0 = 0 and ovf_flag[0] = 1. With wrap_mode = 1 -> acc0 = 15. acc1 unchanged in both cases.
- rot_event held high for 5 cycles -> exactly one update. Event with ch_sel = 3 in a build with NCH = 3, CH_W = 2 -> dropped, no upd_valid.
- clr and an event on the same cycle, channel 1 = 9 with ovf set -> acc1 = 0, ovf_flag[1] = 0, no upd_valid. The next rising event with add 1 -> acc1 = 1.
- Build with WIDTH = 8, NCH = 4, STEP_W = 4: add 15 seventeen times on ch 2 -> acc2 = 255 and saturated; ch 0, 1 and 3 remain 0. Assert rst_n = 0 mid-sequence -> all outputs 0 immediately.
